exp_job_scheduler: RTL and testbench
====================================

# exp_job_scheduler

Sequences the exponent FSMD and the LCD display controller on behalf of two requesters. Each requester submits an (a, n) job. A round-robin arbiter picks one job at a time. The scheduler drives the engine's go pulse, captures the 16-bit result, starts the LCD display and waits for it to finish, then returns the result to the requester that owns the job. It sits above the top-level datapath/FSM pair and the LCD initializer, and replaces the direct wiring of sig_done to the LCD start input.

## Interface
- TIMEOUT_CYCLES, default 4096: maximum cycles the scheduler waits for eng_done.
- TO_W, default 16: width of the timeout counter. TIMEOUT_CYCLES must be less than 2^TO_W.
- clk  in  1  system clock; the block uses only the rising edge.
- rst  in  1  synchronous, active-high reset.
- req0_valid, req1_valid  in  1  job request from requester 0 and requester 1.
- req0_a, req0_n, req1_a, req1_n  in  8  base and exponent for each requester.
- req0_ready, req1_ready  out  1  a job is accepted when valid and ready are both high on a clock edge.
- eng_go  out  1  one-cycle start pulse to the engine.
- eng_a, eng_n  out  8  operands held stable from ISSUE through WAIT_ENG.
- eng_done  in  1  engine completion level (the engine's sig_done).
- eng_result  in  16  engine output register.
- lcd_start  out  1  start level to the LCD controller; high only in DISP.
- lcd_a, lcd_n  out  8  operands of the current job, sent to the LCD.
- lcd_res  out  16  captured result, sent to the LCD.
- lcd_done  in  1  LCD controller finished.
- resp_valid  out  1  one-cycle response pulse.
- resp_id  out  1  requester that owns the response.
- resp_result  out  16  result of the job.
- resp_err  out  1  job timed out.
- busy  out  1  high whenever the state is not IDLE.

## Operation
- States: IDLE, ISSUE, GUARD, WAIT_ENG, DISP, WAIT_LCD, RESP.
- IDLE
  - The arbiter asserts readyX combinationally only for the granted requester.
  - If exactly one valid is high, that requester is granted.
  - If both are high, the requester other than last_grant wins.
  - On acceptance: latch a, n and id; set last_grant to id; go to ISSUE.
- ISSUE: eng_go=1 for exactly one cycle. Go to GUARD.
- GUARD: wait one cycle with eng_done ignored, so a stale done level from the previous job cannot complete this one. Clear the timeout counter. Go to WAIT_ENG.
- WAIT_ENG
  - If eng_done=1: capture eng_result into the result register, clear err, go to DISP.
  - Otherwise, increment the timeout counter.
- DISP: lcd_start=1 for one cycle. Go to WAIT_LCD.
- WAIT_LCD: when lcd_done=1, go to RESP. There is no timeout on this wait.
- RESP: resp_valid=1 for one cycle with the latched id, result and err. Go to IDLE.
- Only one job is ever in flight. Requests that arrive while busy stay pending; the requester holds valid until it sees ready.
- Operand widths pass through unchanged. The result is captured exactly as the engine provides it; the scheduler performs no arithmetic.

## Timing
- Reset values:
  - state=IDLE, last_grant=1 (requester 0 wins the first tie).
  - All outputs are 0: ready, eng_go, eng_a/eng_n, lcd_*, resp_*, busy.
- Reset behaviour: reset asserted in any state returns to IDLE on the next edge. No response is issued for the aborted job.
- Acceptance edge to eng_go high: 1 cycle.
- Engine completion:
  - eng_done is first sampled 2 cycles after the eng_go cycle.
  - If eng_done is seen on WAIT_ENG cycle k, lcd_start is high on cycle k+1.
- Response: resp_valid goes high one cycle after lcd_done is sampled high. Back to IDLE the cycle after resp_valid.
- Minimum job (eng_done and lcd_done already high): acceptance to resp_valid is 6 cycles. The next acceptance can happen the cycle after resp_valid.
- Fairness: with both requesters continuously valid, grants alternate 0, 1, 0, 1, …
- resp_valid and a new acceptance never happen in the same cycle.

## Configuration
- Macro: EXP_SCHED_TIMEOUT_EN.
- With the macro defined:
  - In WAIT_ENG, when the counter reaches TIMEOUT_CYCLES without eng_done, set err=1 and result=16'h0000, then skip DISP and WAIT_LCD and go directly to RESP.
  - The LCD is not started for a failed job.
- Without the macro:
  - The timeout counter is not built and resp_err is tied to 0.
  - WAIT_ENG waits indefinitely for eng_done.

## Test plan
- Single job, bench engine model computing a^n:
  - Stimulus: req0 with a=3, n=4; model asserts done 10 cycles after go; LCD model asserts done after 20 cycles.
  - Required response: eng_go pulses once with eng_a=3, eng_n=4; lcd_res=81; resp_valid with id=0, result=16'd81, err=0.
- Contention:
  - Stimulus: req0 and req1 held valid from reset; jobs (2,5) and (5,2).
  - Required response: grants are 0, 1, 0, 1; results 32 and 25 go to the correct ids.
- Stale done:
  - Stimulus: eng_done held high continuously from before acceptance.
  - Required response: exactly one eng_go pulse; completion no earlier than GUARD+1; minimum latency of 6 cycles holds.
- Timeout (macro defined, TIMEOUT_CYCLES=16):
  - Stimulus: engine never asserts done.
  - Required response: after 16 WAIT_ENG cycles, resp_valid with err=1 and result=0; lcd_start is never asserted.
- Reset mid-job:
  - Stimulus: assert rst during WAIT_LCD.
  - Required response: next cycle busy=0, no resp_valid; a new req1 job with (1, 7) completes with result=1.
- n=0 passthrough:
  - Stimulus: req1 with a=9, n=0; engine model returns 1.
  - Required response: resp result=1, id=1.

Source files
------------

// File: rtl/exp_job_scheduler.sv
// rtl/exp_job_scheduler.sv - round-robin job scheduler sequencing the exponent engine and LCD display
// Optional engine timeout is enabled by defining EXP_SCHED_TIMEOUT_EN.
module exp_job_scheduler #(
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int TO_W           = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    input  logic [7:0]  req0_a,
    input  logic [7:0]  req0_n,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [7:0]  req1_a,
    input  logic [7:0]  req1_n,
    output logic        req1_ready,
    output logic        eng_go,
    output logic [7:0]  eng_a,
    output logic [7:0]  eng_n,
    input  logic        eng_done,
    input  logic [15:0] eng_result,
    output logic        lcd_start,
    output logic [7:0]  lcd_a,
    output logic [7:0]  lcd_n,
    output logic [15:0] lcd_res,
    input  logic        lcd_done,
    output logic        resp_valid,
    output logic        resp_id,
    output logic [15:0] resp_result,
    output logic        resp_err,
    output logic        busy
);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        GUARD,
        WAIT_ENG,
        DISP,
        WAIT_LCD,
        RESP
    } state_t;

    state_t      state;
    state_t      state_nx;
    logic        last_grant;
    logic        id_q;
    logic [7:0]  a_q;
    logic [7:0]  n_q;
    logic [15:0] res_q;
    logic        grant_id;
    logic        accept;
    logic        timeout;

    // On a tie the requester that did not win last time is granted.
    assign grant_id   = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
    assign req0_ready = (state == IDLE) && !rst && req0_valid && !grant_id;
    assign req1_ready = (state == IDLE) && !rst && req1_valid && grant_id;
    assign accept     = req0_ready || req1_ready;

`ifdef EXP_SCHED_TIMEOUT_EN
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    logic [TO_W-1:0] to_cnt;
    logic            err_q;

    assign timeout  = (to_cnt == TO_LAST);
    assign resp_err = err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            to_cnt <= '0;
            err_q  <= 1'b0;
        end else if (accept) begin
            err_q <= 1'b0;
        end else if (state == GUARD) begin
            to_cnt <= '0;
        end else if (state == WAIT_ENG) begin
            if (eng_done) begin
                err_q <= 1'b0;
            end else if (timeout) begin
                err_q <= 1'b1;
            end else begin
                to_cnt <= to_cnt + 1'b1;
            end
        end
    end
`else
    assign timeout  = 1'b0;
    assign resp_err = 1'b0;
`endif

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:     if (accept) state_nx = ISSUE;
            ISSUE:    state_nx = GUARD;
            // GUARD exists so a done level left over from the previous job is never sampled.
            GUARD:    state_nx = WAIT_ENG;
            WAIT_ENG: begin
                if (eng_done) begin
                    state_nx = DISP;
                end else if (timeout) begin
                    state_nx = RESP;
                end
            end
            DISP:     state_nx = WAIT_LCD;
            WAIT_LCD: if (lcd_done) state_nx = RESP;
            RESP:     state_nx = IDLE;
            default:  state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            id_q       <= 1'b0;
            a_q        <= '0;
            n_q        <= '0;
            res_q      <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                a_q        <= grant_id ? req1_a : req0_a;
                n_q        <= grant_id ? req1_n : req0_n;
                id_q       <= grant_id;
                last_grant <= grant_id;
            end
            if (state == WAIT_ENG) begin
                if (eng_done) begin
                    res_q <= eng_result;
                end else if (timeout) begin
                    res_q <= '0;
                end
            end
        end
    end

    assign eng_go      = (state == ISSUE);
    assign eng_a       = a_q;
    assign eng_n       = n_q;
    assign lcd_start   = (state == DISP);
    assign lcd_a       = a_q;
    assign lcd_n       = n_q;
    assign lcd_res     = res_q;
    assign resp_valid  = (state == RESP);
    assign resp_id     = id_q;
    assign resp_result = res_q;
    assign busy        = (state != IDLE);

endmodule

// File: tb/tb_exp_job_scheduler.sv
// tb/tb_exp_job_scheduler.sv - directed self-checking bench for exp_job_scheduler
module tb_exp_job_scheduler;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0_valid = 1'b0;
    logic [7:0]  req0_a = '0;
    logic [7:0]  req0_n = '0;
    logic        req0_ready;
    logic        req1_valid = 1'b0;
    logic [7:0]  req1_a = '0;
    logic [7:0]  req1_n = '0;
    logic        req1_ready;
    logic        eng_go;
    logic [7:0]  eng_a;
    logic [7:0]  eng_n;
    logic        eng_done;
    logic [15:0] eng_result;
    logic        lcd_start;
    logic [7:0]  lcd_a;
    logic [7:0]  lcd_n;
    logic [15:0] lcd_res;
    logic        lcd_done;
    logic        resp_valid;
    logic        resp_id;
    logic [15:0] resp_result;
    logic        resp_err;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    int eng_delay  = 10;
    int lcd_delay  = 20;
    bit stale_done = 1'b0;
    bit eng_hang   = 1'b0;
    bit lcd_force  = 1'b0;

    int          eng_cnt    = 0;
    int          lcd_cnt    = 0;
    logic        eng_done_m = 1'b0;
    logic        lcd_done_m = 1'b0;
    logic [15:0] eng_res_m  = '0;
    int          go_cnt     = 0;
    int          start_cnt  = 0;
    int          resp_cnt   = 0;

    always #5 clk = ~clk;

    exp_job_scheduler #(
        .TIMEOUT_CYCLES(16),
        .TO_W(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req0_valid(req0_valid),
        .req0_a(req0_a),
        .req0_n(req0_n),
        .req0_ready(req0_ready),
        .req1_valid(req1_valid),
        .req1_a(req1_a),
        .req1_n(req1_n),
        .req1_ready(req1_ready),
        .eng_go(eng_go),
        .eng_a(eng_a),
        .eng_n(eng_n),
        .eng_done(eng_done),
        .eng_result(eng_result),
        .lcd_start(lcd_start),
        .lcd_a(lcd_a),
        .lcd_n(lcd_n),
        .lcd_res(lcd_res),
        .lcd_done(lcd_done),
        .resp_valid(resp_valid),
        .resp_id(resp_id),
        .resp_result(resp_result),
        .resp_err(resp_err),
        .busy(busy)
    );

    function automatic logic [15:0] pow16(input logic [7:0] a, input logic [7:0] n);
        logic [15:0] r;
        r = 16'd1;
        for (int i = 0; i < int'(n); i++) r = r * {8'h00, a};
        return r;
    endfunction

    assign eng_done   = eng_done_m | stale_done;
    assign eng_result = eng_res_m;
    assign lcd_done   = lcd_done_m | lcd_force;

    // Engine model: result computed at go, done level raised after eng_delay cycles.
    always @(posedge clk) begin
        if (eng_go) begin
            eng_res_m  <= pow16(eng_a, eng_n);
            eng_done_m <= 1'b0;
            eng_cnt    <= eng_hang ? -1 : eng_delay;
        end else if (eng_cnt > 0) begin
            eng_cnt <= eng_cnt - 1;
            if (eng_cnt == 1) eng_done_m <= 1'b1;
        end
    end

    always @(posedge clk) begin
        if (lcd_start) begin
            lcd_done_m <= 1'b0;
            lcd_cnt    <= lcd_delay;
        end else if (lcd_cnt > 0) begin
            lcd_cnt <= lcd_cnt - 1;
            if (lcd_cnt == 1) lcd_done_m <= 1'b1;
        end
    end

    always @(posedge clk) begin
        if (eng_go) go_cnt <= go_cnt + 1;
        if (lcd_start) start_cnt <= start_cnt + 1;
        if (resp_valid) resp_cnt <= resp_cnt + 1;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    task automatic submit(input logic id, input logic [7:0] a, input logic [7:0] n, output bit ok);
        ok = 1'b0;
        if (id) begin
            req1_valid = 1'b1; req1_a = a; req1_n = n;
        end else begin
            req0_valid = 1'b1; req0_a = a; req0_n = n;
        end
        #1;
        for (int i = 0; i < 200; i++) begin
            if ((id ? req1_ready : req0_ready) === 1'b1) begin
                ok = 1'b1;
                break;
            end
            tick;
        end
        tick;
        if (id) req1_valid = 1'b0;
        else req0_valid = 1'b0;
    endtask

    task automatic wait_resp(input int bound, output bit got, output int cyc);
        got = 1'b0;
        cyc = 0;
        while (!got && cyc < bound) begin
            tick;
            cyc++;
            if (resp_valid === 1'b1) got = 1'b1;
        end
    endtask

    initial begin
        bit ok;
        bit got;
        int cyc;
        int g0;
        int l0;
        int r0;
        bit seen;

        // Reset state, with both requesters already asking
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        tick; tick; tick;
        check("rst_ready0", req0_ready, 0);
        check("rst_ready1", req1_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_eng_go", eng_go, 0);
        check("rst_eng_a", eng_a, 0);
        check("rst_lcd_start", lcd_start, 0);
        check("rst_lcd_res", lcd_res, 0);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_resp_err", resp_err, 0);
        rst = 1'b0;
        #1;
        check("first_tie_ready0", req0_ready, 1);
        check("first_tie_ready1", req1_ready, 0);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        tick;

        // Single job 3^4
        g0 = go_cnt; l0 = start_cnt;
        eng_delay = 10; lcd_delay = 20;
        submit(1'b0, 8'd3, 8'd4, ok);
        check("single_accept", ok, 1);
        check("single_eng_go", eng_go, 1);
        check("single_eng_a", eng_a, 3);
        check("single_eng_n", eng_n, 4);
        check("single_busy", busy, 1);
        wait_resp(200, got, cyc);
        check("single_got_resp", got, 1);
        check("single_resp_id", resp_id, 0);
        check("single_resp_result", resp_result, 81);
        check("single_resp_err", resp_err, 0);
        check("single_lcd_res", lcd_res, 81);
        check("single_go_pulses", go_cnt - g0, 1);
        check("single_lcd_pulses", start_cnt - l0, 1);
        tick;
        check("single_idle_after", busy, 0);

        // Stale done level and minimum latency
        stale_done = 1'b1; lcd_force = 1'b1;
        g0 = go_cnt;
        submit(1'b0, 8'd2, 8'd3, ok);
        check("stale_accept", ok, 1);
        wait_resp(50, got, cyc);
        check("stale_got_resp", got, 1);
        check("stale_min_latency", cyc, 5);
        check("stale_result", resp_result, 8);
        check("stale_go_pulses", go_cnt - g0, 1);
        req0_valid = 1'b1;
        #1;
        check("no_accept_in_resp", req0_ready, 0);
        tick;
        check("accept_after_resp", req0_ready, 1);
        check("idle_after_resp", busy, 0);
        req0_valid = 1'b0;
        stale_done = 1'b0; lcd_force = 1'b0;
        tick;

        // n = 0 passthrough
        eng_delay = 4; lcd_delay = 3;
        submit(1'b1, 8'd9, 8'd0, ok);
        check("n0_accept", ok, 1);
        wait_resp(100, got, cyc);
        check("n0_got_resp", got, 1);
        check("n0_resp_id", resp_id, 1);
        check("n0_resp_result", resp_result, 1);
        tick;

        // Contention from reset: grants alternate 0,1,0,1
        rst = 1'b1;
        tick; tick;
        rst = 1'b0;
        req0_a = 8'd2; req0_n = 8'd5; req0_valid = 1'b1;
        req1_a = 8'd5; req1_n = 8'd2; req1_valid = 1'b1;
        for (int j = 0; j < 4; j++) begin
            #1;
            seen = 1'b0;
            for (int i = 0; i < 100; i++) begin
                if (req0_ready === 1'b1 || req1_ready === 1'b1) begin
                    seen = 1'b1;
                    break;
                end
                tick;
            end
            check("cont_ready_seen", seen, 1);
            check("cont_grant", req1_ready, j % 2);
            check("cont_onehot", req0_ready & req1_ready, 0);
            tick;
            wait_resp(100, got, cyc);
            check("cont_got_resp", got, 1);
            check("cont_resp_id", resp_id, j % 2);
            check("cont_resp_result", resp_result, (j % 2 == 1) ? 25 : 32);
            if (j == 3) begin
                req0_valid = 1'b0;
                req1_valid = 1'b0;
            end
        end
        tick;

        // Reset during WAIT_LCD aborts the job silently
        eng_delay = 3; lcd_delay = 30;
        submit(1'b0, 8'd3, 8'd2, ok);
        check("abort_accept", ok, 1);
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (lcd_start === 1'b1) begin
                seen = 1'b1;
                break;
            end
            tick;
        end
        check("abort_lcd_started", seen, 1);
        tick;
        check("abort_busy_wait_lcd", busy, 1);
        r0 = resp_cnt;
        rst = 1'b1;
        tick;
        check("abort_busy_cleared", busy, 0);
        check("abort_no_resp", resp_valid, 0);
        rst = 1'b0;
        repeat (40) tick;
        check("abort_resp_count", resp_cnt - r0, 0);
        lcd_delay = 5;
        submit(1'b1, 8'd1, 8'd7, ok);
        check("post_abort_accept", ok, 1);
        wait_resp(100, got, cyc);
        check("post_abort_got_resp", got, 1);
        check("post_abort_id", resp_id, 1);
        check("post_abort_result", resp_result, 1);
        tick;

`ifdef EXP_SCHED_TIMEOUT_EN
        // Engine never completes: 16 WAIT_ENG cycles then an error response
        eng_hang = 1'b1;
        l0 = start_cnt;
        submit(1'b0, 8'd4, 8'd4, ok);
        check("to_accept", ok, 1);
        wait_resp(100, got, cyc);
        check("to_got_resp", got, 1);
        check("to_latency", cyc, 18);
        check("to_resp_err", resp_err, 1);
        check("to_resp_result", resp_result, 0);
        check("to_no_lcd", start_cnt - l0, 0);
        eng_hang = 1'b0;
        tick;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
